// File: rtl/basilisk_register_scoreboard_pkg.sv
// Shared types for the Basilisk register-status scoreboard: the decode-side
// register status encoding plus register-file sizing.
package basilisk_register_scoreboard_pkg;

   typedef enum logic [1:0] {
      VALID     = 2'd0,
      INVALID   = 2'd1,
      SLIDEUP   = 2'd2,
      SLIDEDOWN = 2'd3
   } basilisk_decode_reg_status_t;

   localparam int BASILISK_REG_COUNT = 32;

   typedef logic [4:0] basilisk_reg_addr_t;

endpackage

// File: rtl/basilisk_register_scoreboard_if.sv
// Issue/retire handshake between decode, writeback and the register scoreboard.
interface basilisk_register_scoreboard_if;
   import basilisk_register_scoreboard_pkg::*;

   logic                        issue_valid;
   logic                        issue_ready;
   basilisk_reg_addr_t          issue_rd;
   basilisk_decode_reg_status_t issue_mode;
   logic                        retire_valid;
   basilisk_reg_addr_t          retire_rd;

   modport master (
      output issue_valid, issue_rd, issue_mode, retire_valid, retire_rd,
      input  issue_ready
   );

   modport slave (
      input  issue_valid, issue_rd, issue_mode, retire_valid, retire_rd,
      output issue_ready
   );

endinterface

// File: rtl/basilisk_scoreboard_entry.sv
// One register's pending-write tracker: outstanding-write count and the kind
// of write (normal or slide) that is currently pending.
module basilisk_scoreboard_entry
   import basilisk_register_scoreboard_pkg::*;
#(
   parameter int MAX_PENDING = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        issue_hit,
   input  logic                        retire_hit,
   input  basilisk_decode_reg_status_t issue_mode,
   output basilisk_decode_reg_status_t status,
   output logic                        ready_for,
   output logic                        pending_next
);

   localparam int CNT_W = $clog2(MAX_PENDING + 1);

   logic [CNT_W-1:0]            count;
   logic [CNT_W-1:0]            count_next;
   basilisk_decode_reg_status_t mode;
   basilisk_decode_reg_status_t mode_next;
   logic                        dec;

   // Retires against an empty entry are ignored so the counter never underflows.
   always_comb begin
      dec        = retire_hit && (count != '0);
      count_next = count;
      mode_next  = mode;
      if (flush) begin
         count_next = '0;
      end else begin
         if (issue_hit && (count == '0))
            mode_next = issue_mode;
         case ({issue_hit, dec})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         mode  <= VALID;
      end else begin
         count <= count_next;
         mode  <= mode_next;
      end
   end

   assign status       = (count == '0) ? VALID : mode;
   assign ready_for    = (count == '0) || ((mode == issue_mode) && (count < CNT_W'(MAX_PENDING)));
   assign pending_next = (count_next != '0);

endmodule

// File: rtl/basilisk_register_scoreboard.sv
// Register scoreboard: tracks outstanding writes to the 32 FP/vector registers
// and publishes a per-register status for decode dependency checks.
module basilisk_register_scoreboard
   import basilisk_register_scoreboard_pkg::*;
#(
   parameter int MAX_PENDING = 3
) (
   input  logic                                                     clk,
   input  logic                                                     rst,
   basilisk_register_scoreboard_if.slave                            bus,
   input  logic                                                     flush,
   output basilisk_decode_reg_status_t [BASILISK_REG_COUNT-1:0]     reg_status,
   output logic                                                     busy,
   output logic                                                     error
);

   logic [BASILISK_REG_COUNT-1:0] ready_vec;
   logic [BASILISK_REG_COUNT-1:0] pending_next_vec;
   logic                          issue_fire;
   logic                          violation;

   assign bus.issue_ready = ready_vec[bus.issue_rd];
   assign issue_fire      = bus.issue_valid && bus.issue_ready;

   // A fired issue carrying VALID is a protocol error and must not touch state.
   for (genvar i = 0; i < BASILISK_REG_COUNT; i++) begin : g_entry
      basilisk_scoreboard_entry #(
         .MAX_PENDING (MAX_PENDING)
      ) u_entry (
         .clk          (clk),
         .rst          (rst),
         .flush        (flush),
         .issue_hit    (issue_fire && (bus.issue_rd == basilisk_reg_addr_t'(i)) && (bus.issue_mode != VALID)),
         .retire_hit   (bus.retire_valid && (bus.retire_rd == basilisk_reg_addr_t'(i))),
         .issue_mode   (bus.issue_mode),
         .status       (reg_status[i]),
         .ready_for    (ready_vec[i]),
         .pending_next (pending_next_vec[i])
      );
   end

   assign violation = !flush && ((issue_fire && (bus.issue_mode == VALID)) ||
                                 (bus.retire_valid && (reg_status[bus.retire_rd] == VALID)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy  <= 1'b0;
         error <= 1'b0;
      end else begin
         busy  <= |pending_next_vec;
         error <= error || violation;
      end
   end

endmodule
